// File: rtl/lf_reader.sv
// lf_reader: streams one stored frame out of a frame buffer when the
// compensator flags the frame as written (rising edge of LF_conceal).
//
// Ports:
//   CLK, reset            clock, asynchronous active-low reset
//   height, width         frame size, captured when a readout starts
//   LF_conceal            frame-written flag; a rising edge starts a readout
//   rd_addr/rd_en/rd_data frame-buffer read port, data one cycle after rd_en
//   pix_*                 valid/ready pixel stream with sol/eol/eof markers
//   busy, done            readout in progress / one-cycle completion pulse
module lf_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [7:0]        height,
  input  logic [7:0]        width,
  input  logic              LF_conceal,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sol;
    logic              eol;
    logic              eof;
  } ent_t;

  state_t      state, state_nxt;
  logic        lf_q, start_q;
  logic [7:0]  h_q, w_q, col, row;
  logic        last_col, last_pix;
  logic        inflight;
  logic [2:0]  fl_q;          // {sol,eol,eof} of the read in flight
  ent_t        fifo [2];
  logic        wp, rp;
  logic [1:0]  count;
  logic [1:0]  committed;
  logic        xfer;

  assign last_col  = (col == w_q - 8'd1);
  assign last_pix  = last_col && (row == h_q - 8'd1);

  assign pix_valid = (count != 2'd0);
  assign xfer      = pix_valid & pix_ready;
  // Flags are gated so nothing stale is visible when the FIFO is empty.
  assign pix_data  = fifo[rp].data;
  assign pix_sol   = pix_valid & fifo[rp].sol;
  assign pix_eol   = pix_valid & fifo[rp].eol;
  assign pix_eof   = pix_valid & fifo[rp].eof;

  // Slots already spoken for: stored entries plus the read still returning,
  // minus the entry leaving this cycle. A new read only if one slot is free.
  assign committed = count + {1'b0, inflight} - {1'b0, xfer};
  assign rd_en     = (state == RUN) && (committed < 2'd2);

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_q) state_nxt = (height != 8'd0 && width != 8'd0) ? RUN : FIN;
      RUN:     if (rd_en && last_pix) state_nxt = DRAIN;
      DRAIN:   if (xfer && pix_eof) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lf_q     <= 1'b1;   // a flag already high through reset is not an edge
      start_q  <= 1'b0;
      h_q      <= '0;
      w_q      <= '0;
      col      <= '0;
      row      <= '0;
      rd_addr  <= '0;
      inflight <= 1'b0;
      fl_q     <= '0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      count    <= '0;
    end else begin
      state   <= state_nxt;
      lf_q    <= LF_conceal;
      // Edges seen outside IDLE are dropped here, so none can be queued.
      start_q <= LF_conceal & ~lf_q & (state == IDLE);

      if (state == IDLE && start_q) begin
        h_q <= height;
        w_q <= width;
        col <= '0;
        row <= '0;
        if (height != 8'd0 && width != 8'd0) rd_addr <= '0;
      end

      if (rd_en) begin
        fl_q <= {col == 8'd0, last_col, last_pix};
        // Address stops on the last pixel so it never wraps and holds after RUN.
        if (!last_pix) begin
          rd_addr <= rd_addr + ADDR_W'(1);
          if (last_col) begin
            col <= '0;
            row <= row + 8'd1;
          end else begin
            col <= col + 8'd1;
          end
        end
      end

      inflight <= rd_en;
      if (inflight) begin
        fifo[wp] <= {rd_data, fl_q};
        wp       <= ~wp;
      end
      if (xfer) rp <= ~rp;
      count <= committed;
    end
  end

endmodule
